// File: rtl/axis_snooper_trunc.sv
// axis_snooper_trunc
// Watches a monitored AXI-Stream link and copies each packet into a buffer
// handed out by the ping-pong packet memory. Packets longer than the buffer
// are truncated (length still counted), packets arriving while no buffer is
// held are dropped and counted, and the write port has a selectable
// latency of one or two register stages.

module axis_snooper_trunc #(
    parameter int DATA_WIDTH          = 64,
    parameter int ADDR_WIDTH          = 9,
    parameter int INC_WIDTH           = 8,
    parameter int LEN_WIDTH           = 16,
    parameter int CNT_WIDTH           = 32,
    parameter int PESS                = 0,
    parameter int ENABLE_BACKPRESSURE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   sn_TDATA,
    input  logic [DATA_WIDTH/8-1:0] sn_TKEEP,
    input  logic                    sn_TVALID,
    input  logic                    sn_TREADY,
    input  logic                    sn_TLAST,
    output logic                    sn_bp_TREADY,
    output logic [ADDR_WIDTH-1:0]   sn_addr,
    output logic [DATA_WIDTH-1:0]   sn_wr_data,
    output logic                    sn_wr_en,
    output logic [INC_WIDTH-1:0]    sn_byte_inc,
    output logic                    sn_done,
    output logic [LEN_WIDTH-1:0]    pkt_len,
    output logic                    truncated,
    input  logic                    rdy_for_sn,
    output logic                    rdy_for_sn_ack,
    output logic                    packet_dropped_inc,
    output logic [CNT_WIDTH-1:0]    drop_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ARMED,
        ST_CAPTURE,
        ST_DROP
    } state_t;

    // Number of set byte enables in one beat.
    function automatic logic [INC_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [INC_WIDTH-1:0] count;
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + INC_WIDTH'(keep[i]);
        end
        return count;
    endfunction

    state_t state;
    state_t state_nxt;

    // The index carries one extra bit so "buffer full" is simply its MSB.
    logic [ADDR_WIDTH:0]   word_idx;
    logic [ADDR_WIDTH:0]   word_idx_nxt;
    logic [LEN_WIDTH-1:0]  len_acc;
    logic [LEN_WIDTH-1:0]  len_acc_nxt;
    logic                  trunc_acc;
    logic                  trunc_acc_nxt;

    logic                  beat;
    logic [INC_WIDTH-1:0]  beat_bytes;
    logic                  in_range;
    logic [LEN_WIDTH:0]    len_sum;
    logic [LEN_WIDTH-1:0]  len_sat;
    logic                  trunc_now;

    logic                  wr_en_c;
    logic                  done_c;
    logic                  drop_c;
    logic                  ack_c;
    logic                  done_busy;

    // First write-port stage.
    logic                  s1_wr_en;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_wr_data;
    logic [INC_WIDTH-1:0]  s1_byte_inc;
    logic                  s1_done;
    logic [LEN_WIDTH-1:0]  s1_pkt_len;
    logic                  s1_truncated;

    logic                  drop_inc_r;
    logic [CNT_WIDTH-1:0]  drop_count_r;

    // Ready towards the source: only withheld while waiting for a buffer
    // when backpressure is enabled.
    always_comb begin
        sn_bp_TREADY = sn_TREADY;
        if ((ENABLE_BACKPRESSURE != 0) && (state == ST_WAIT)) begin
            sn_bp_TREADY = 1'b0;
        end
    end

    assign beat = sn_TVALID && sn_bp_TREADY;

    // Per-beat byte count, buffer-space test and saturating length sum.
    always_comb begin
        beat_bytes = popcount(sn_TKEEP);
        in_range   = ~word_idx[ADDR_WIDTH];
        len_sum    = {1'b0, len_acc} + (LEN_WIDTH + 1)'(beat_bytes);
        len_sat    = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
        trunc_now  = trunc_acc | ~in_range;
    end

    // A completion still travelling through the write pipe holds off the next
    // buffer ack, so a new buffer is never taken before the old one is closed.
    assign done_busy = s1_done | sn_done;

    // Next-state, capture bookkeeping and one-cycle strobes.
    always_comb begin
        state_nxt     = state;
        word_idx_nxt  = word_idx;
        len_acc_nxt   = len_acc;
        trunc_acc_nxt = trunc_acc;
        wr_en_c       = 1'b0;
        done_c        = 1'b0;
        drop_c        = 1'b0;
        ack_c         = 1'b0;

        case (state)
            ST_WAIT: begin
                if (beat) begin
                    drop_c = 1'b1;
                    if (!sn_TLAST) begin
                        state_nxt = ST_DROP;
                    end
                end else if (rdy_for_sn && !done_busy) begin
                    ack_c     = 1'b1;
                    state_nxt = ST_ARMED;
                end
            end

            ST_ARMED, ST_CAPTURE: begin
                if (beat) begin
                    state_nxt     = ST_CAPTURE;
                    len_acc_nxt   = len_sat;
                    trunc_acc_nxt = trunc_now;
                    if (in_range) begin
                        wr_en_c      = 1'b1;
                        word_idx_nxt = word_idx + (ADDR_WIDTH + 1)'(1);
                    end
                    if (sn_TLAST) begin
                        done_c        = 1'b1;
                        state_nxt     = ST_WAIT;
                        word_idx_nxt  = '0;
                        len_acc_nxt   = '0;
                        trunc_acc_nxt = 1'b0;
                    end
                end
            end

            ST_DROP: begin
                if (beat && sn_TLAST) begin
                    state_nxt = ST_WAIT;
                end
            end

            default: begin
                state_nxt = ST_WAIT;
            end
        endcase
    end

    assign rdy_for_sn_ack = ack_c;

    // State and capture-progress registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            word_idx  <= '0;
            len_acc   <= '0;
            trunc_acc <= 1'b0;
        end else begin
            state     <= state_nxt;
            word_idx  <= word_idx_nxt;
            len_acc   <= len_acc_nxt;
            trunc_acc <= trunc_acc_nxt;
        end
    end

    // First write-port stage; completion info travels alongside the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_wr_en     <= 1'b0;
            s1_addr      <= '0;
            s1_wr_data   <= '0;
            s1_byte_inc  <= '0;
            s1_done      <= 1'b0;
            s1_pkt_len   <= '0;
            s1_truncated <= 1'b0;
        end else begin
            s1_wr_en     <= wr_en_c;
            s1_done      <= done_c;
            s1_pkt_len   <= done_c ? len_sat : '0;
            s1_truncated <= done_c & trunc_now;
            if (wr_en_c) begin
                s1_addr     <= word_idx[ADDR_WIDTH-1:0];
                s1_wr_data  <= sn_TDATA;
                s1_byte_inc <= beat_bytes;
            end
        end
    end

    generate
        if (PESS != 0) begin : g_pess
            logic                  s2_wr_en;
            logic [ADDR_WIDTH-1:0] s2_addr;
            logic [DATA_WIDTH-1:0] s2_wr_data;
            logic [INC_WIDTH-1:0]  s2_byte_inc;
            logic                  s2_done;
            logic [LEN_WIDTH-1:0]  s2_pkt_len;
            logic                  s2_truncated;

            // Extra register stage for timing-pessimistic memory paths.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_wr_en     <= 1'b0;
                    s2_addr      <= '0;
                    s2_wr_data   <= '0;
                    s2_byte_inc  <= '0;
                    s2_done      <= 1'b0;
                    s2_pkt_len   <= '0;
                    s2_truncated <= 1'b0;
                end else begin
                    s2_wr_en     <= s1_wr_en;
                    s2_addr      <= s1_addr;
                    s2_wr_data   <= s1_wr_data;
                    s2_byte_inc  <= s1_byte_inc;
                    s2_done      <= s1_done;
                    s2_pkt_len   <= s1_pkt_len;
                    s2_truncated <= s1_truncated;
                end
            end

            assign sn_wr_en    = s2_wr_en;
            assign sn_addr     = s2_addr;
            assign sn_wr_data  = s2_wr_data;
            assign sn_byte_inc = s2_byte_inc;
            assign sn_done     = s2_done;
            assign pkt_len     = s2_pkt_len;
            assign truncated   = s2_truncated;
        end else begin : g_direct
            assign sn_wr_en    = s1_wr_en;
            assign sn_addr     = s1_addr;
            assign sn_wr_data  = s1_wr_data;
            assign sn_byte_inc = s1_byte_inc;
            assign sn_done     = s1_done;
            assign pkt_len     = s1_pkt_len;
            assign truncated   = s1_truncated;
        end
    endgenerate

    // Dropped-packet pulse and saturating counter, one cycle after the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_inc_r   <= 1'b0;
            drop_count_r <= '0;
        end else begin
            drop_inc_r <= drop_c;
            if (drop_c && (drop_count_r != '1)) begin
                drop_count_r <= drop_count_r + CNT_WIDTH'(1);
            end
        end
    end

    assign packet_dropped_inc = drop_inc_r;
    assign drop_count         = drop_count_r;

endmodule

// File: tb/tb_axis_snooper_trunc.sv
// Directed bench for axis_snooper_trunc. Instance A: 4-word buffer, 2-bit drop
// counter, latency 1, no backpressure. Instance B: 4-word buffer, latency 2,
// backpressure enabled.

module tb_axis_snooper_trunc;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic [63:0] a_TDATA;
    logic [7:0]  a_TKEEP;
    logic        a_TVALID, a_TREADY, a_TLAST, a_bp_TREADY;
    logic [1:0]  a_addr;
    logic [63:0] a_wr_data;
    logic        a_wr_en;
    logic [7:0]  a_byte_inc;
    logic        a_done;
    logic [15:0] a_pkt_len;
    logic        a_trunc;
    logic        a_rdy, a_ack, a_drop_inc;
    logic [1:0]  a_drop_count;

    // Instance B signals
    logic [63:0] b_TDATA;
    logic [7:0]  b_TKEEP;
    logic        b_TVALID, b_TREADY, b_TLAST, b_bp_TREADY;
    logic [1:0]  b_addr;
    logic [63:0] b_wr_data;
    logic        b_wr_en;
    logic [7:0]  b_byte_inc;
    logic        b_done;
    logic [15:0] b_pkt_len;
    logic        b_trunc;
    logic        b_rdy, b_ack, b_drop_inc;
    logic [1:0]  b_drop_count;

    axis_snooper_trunc #(
        .DATA_WIDTH(64), .ADDR_WIDTH(2), .INC_WIDTH(8), .LEN_WIDTH(16),
        .CNT_WIDTH(2), .PESS(0), .ENABLE_BACKPRESSURE(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .sn_TDATA(a_TDATA), .sn_TKEEP(a_TKEEP), .sn_TVALID(a_TVALID),
        .sn_TREADY(a_TREADY), .sn_TLAST(a_TLAST), .sn_bp_TREADY(a_bp_TREADY),
        .sn_addr(a_addr), .sn_wr_data(a_wr_data), .sn_wr_en(a_wr_en),
        .sn_byte_inc(a_byte_inc), .sn_done(a_done), .pkt_len(a_pkt_len),
        .truncated(a_trunc), .rdy_for_sn(a_rdy), .rdy_for_sn_ack(a_ack),
        .packet_dropped_inc(a_drop_inc), .drop_count(a_drop_count)
    );

    axis_snooper_trunc #(
        .DATA_WIDTH(64), .ADDR_WIDTH(2), .INC_WIDTH(8), .LEN_WIDTH(16),
        .CNT_WIDTH(2), .PESS(1), .ENABLE_BACKPRESSURE(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .sn_TDATA(b_TDATA), .sn_TKEEP(b_TKEEP), .sn_TVALID(b_TVALID),
        .sn_TREADY(b_TREADY), .sn_TLAST(b_TLAST), .sn_bp_TREADY(b_bp_TREADY),
        .sn_addr(b_addr), .sn_wr_data(b_wr_data), .sn_wr_en(b_wr_en),
        .sn_byte_inc(b_byte_inc), .sn_done(b_done), .pkt_len(b_pkt_len),
        .truncated(b_trunc), .rdy_for_sn(b_rdy), .rdy_for_sn_ack(b_ack),
        .packet_dropped_inc(b_drop_inc), .drop_count(b_drop_count)
    );

    // Event logs filled by the monitors; scenarios compare against deltas.
    int          a_nwr = 0, a_ndone = 0, a_nack = 0, a_ndrop = 0;
    logic [1:0]  a_wr_addr [64];
    logic [7:0]  a_wr_inc  [64];
    logic [63:0] a_wr_dat  [64];
    int unsigned a_wr_cyc  [64];
    logic [15:0] a_done_len;
    logic        a_done_trunc;
    int unsigned a_done_cyc, a_ack_cyc;

    int          b_nwr = 0, b_ndone = 0, b_nack = 0, b_ndrop = 0;
    logic [1:0]  b_wr_addr [64];
    logic [7:0]  b_wr_inc  [64];
    int unsigned b_wr_cyc  [64];
    logic [15:0] b_done_len;
    logic        b_done_trunc;
    int unsigned b_done_cyc;

    // Record instance A output events mid-cycle.
    always @(negedge clk) begin
        if (a_wr_en) begin
            if (a_nwr < 64) begin
                a_wr_addr[a_nwr] = a_addr;
                a_wr_inc[a_nwr]  = a_byte_inc;
                a_wr_dat[a_nwr]  = a_wr_data;
                a_wr_cyc[a_nwr]  = cyc;
            end
            a_nwr++;
        end
        if (a_done) begin
            a_ndone++;
            a_done_len   = a_pkt_len;
            a_done_trunc = a_trunc;
            a_done_cyc   = cyc;
        end
        if (a_ack) begin
            a_nack++;
            a_ack_cyc = cyc;
        end
        if (a_drop_inc) a_ndrop++;
    end

    // Record instance B output events mid-cycle.
    always @(negedge clk) begin
        if (b_wr_en) begin
            if (b_nwr < 64) begin
                b_wr_addr[b_nwr] = b_addr;
                b_wr_inc[b_nwr]  = b_byte_inc;
                b_wr_cyc[b_nwr]  = cyc;
            end
            b_nwr++;
        end
        if (b_done) begin
            b_ndone++;
            b_done_len   = b_pkt_len;
            b_done_trunc = b_trunc;
            b_done_cyc   = cyc;
        end
        if (b_ack) b_nack++;
        if (b_drop_inc) b_ndrop++;
    end

    // Hard stop if something hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat on instance A (sel=0, always accepted) or B (sel=1,
    // held until the DUT shows ready); returns the cycle in which it fired.
    task automatic applyStimulus(input bit sel, input logic [63:0] d, input logic [7:0] k,
                                 input logic l, output int unsigned bc);
        bit fired;
        bc = 0;
        fired = 1'b0;
        if (!sel) begin
            a_TDATA = d; a_TKEEP = k; a_TLAST = l; a_TVALID = 1'b1;
            @(negedge clk);
            bc = cyc;
            @(posedge clk); #1;
            a_TVALID = 1'b0; a_TLAST = 1'b0;
        end else begin
            b_TDATA = d; b_TKEEP = k; b_TLAST = l; b_TVALID = 1'b1;
            for (int n = 0; n < 50 && !fired; n++) begin
                @(negedge clk);
                if (b_bp_TREADY) begin
                    fired = 1'b1;
                    bc = cyc;
                end
            end
            if (!fired) checkOutput("bBeatTimeout", 64'd0, 64'd1);
            @(posedge clk); #1;
            b_TVALID = 1'b0; b_TLAST = 1'b0;
        end
    endtask

    int unsigned bc, last_bc;
    int unsigned b_bc [3];
    int w0, d0, k0, p0, nbp;
    logic [63:0] pat [6];

    initial begin
        rst_n = 1'b0;
        a_TDATA = '0; a_TKEEP = '0; a_TVALID = 1'b0; a_TREADY = 1'b1; a_TLAST = 1'b0; a_rdy = 1'b0;
        b_TDATA = '0; b_TKEEP = '0; b_TVALID = 1'b0; b_TREADY = 1'b1; b_TLAST = 1'b0; b_rdy = 1'b0;
        pat[0] = 64'h1111_0000_0000_0001; pat[1] = 64'h2222_0000_0000_0002;
        pat[2] = 64'h3333_0000_0000_0003; pat[3] = 64'h4444_0000_0000_0004;
        pat[4] = 64'h5555_0000_0000_0005; pat[5] = 64'h6666_0000_0000_0006;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstWrEn",     64'(a_wr_en), 64'd0);
        checkOutput("rstAddr",     64'(a_addr), 64'd0);
        checkOutput("rstWrData",   a_wr_data, 64'd0);
        checkOutput("rstByteInc",  64'(a_byte_inc), 64'd0);
        checkOutput("rstDone",     64'(a_done), 64'd0);
        checkOutput("rstPktLen",   64'(a_pkt_len), 64'd0);
        checkOutput("rstTrunc",    64'(a_trunc), 64'd0);
        checkOutput("rstAck",      64'(a_ack), 64'd0);
        checkOutput("rstDropInc",  64'(a_drop_inc), 64'd0);
        checkOutput("rstDropCnt",  64'(a_drop_count), 64'd0);
        checkOutput("rstBpFollow", 64'(a_bp_TREADY), 64'd1);
        checkOutput("rstBpHeldB",  64'(b_bp_TREADY), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Basic capture: 3 beats FF,FF,0F
        w0 = a_nwr; d0 = a_ndone; k0 = a_nack;
        a_rdy = 1'b1; idle(1); a_rdy = 1'b0;
        applyStimulus(0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, bc);
        applyStimulus(0, 64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0, bc);
        applyStimulus(0, 64'h0000_0000_CAFE_F00D, 8'h0F, 1'b1, last_bc);
        idle(3);
        checkOutput("basicAcks",   64'(a_nack - k0), 64'd1);
        checkOutput("basicWrites", 64'(a_nwr - w0), 64'd3);
        for (int i = 0; i < 3; i++) checkOutput("basicAddr", 64'(a_wr_addr[w0+i]), 64'(i));
        checkOutput("basicInc0",   64'(a_wr_inc[w0]), 64'd8);
        checkOutput("basicInc1",   64'(a_wr_inc[w0+1]), 64'd8);
        checkOutput("basicInc2",   64'(a_wr_inc[w0+2]), 64'd4);
        checkOutput("basicData0",  a_wr_dat[w0], 64'h0123_4567_89AB_CDEF);
        checkOutput("basicData2",  a_wr_dat[w0+2], 64'h0000_0000_CAFE_F00D);
        checkOutput("basicLatency", 64'(a_wr_cyc[w0+2] - last_bc), 64'd1);
        checkOutput("basicDones",  64'(a_ndone - d0), 64'd1);
        checkOutput("basicLen",    64'(a_done_len), 64'd20);
        checkOutput("basicTrunc",  64'(a_done_trunc), 64'd0);
        checkOutput("basicDoneCyc", 64'(a_done_cyc), 64'(a_wr_cyc[w0+2]));

        // Truncation: 6 full beats into a 4-word buffer
        w0 = a_nwr; d0 = a_ndone;
        a_rdy = 1'b1; idle(1); a_rdy = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(0, pat[i], 8'hFF, (i == 5), last_bc);
        idle(3);
        checkOutput("truncWrites", 64'(a_nwr - w0), 64'd4);
        checkOutput("truncAddr3",  64'(a_wr_addr[w0+3]), 64'd3);
        checkOutput("truncData3",  a_wr_dat[w0+3], pat[3]);
        checkOutput("truncDones",  64'(a_ndone - d0), 64'd1);
        checkOutput("truncLen",    64'(a_done_len), 64'd48);
        checkOutput("truncFlag",   64'(a_done_trunc), 64'd1);
        checkOutput("truncDoneCyc", 64'(a_done_cyc - last_bc), 64'd1);

        // Drops without a buffer; buffer offered mid-way through the second
        w0 = a_nwr; d0 = a_ndone; k0 = a_nack; p0 = a_ndrop;
        applyStimulus(0, pat[0], 8'hFF, 1'b0, bc);
        applyStimulus(0, pat[1], 8'hFF, 1'b1, bc);
        applyStimulus(0, pat[2], 8'hFF, 1'b0, bc);
        a_rdy = 1'b1;
        applyStimulus(0, pat[3], 8'hFF, 1'b0, bc);
        applyStimulus(0, pat[4], 8'hFF, 1'b1, last_bc);
        idle(1);
        a_rdy = 1'b0;
        idle(2);
        checkOutput("dropWrites",  64'(a_nwr - w0), 64'd0);
        checkOutput("dropPulses",  64'(a_ndrop - p0), 64'd2);
        checkOutput("dropCount",   64'(a_drop_count), 64'd2);
        checkOutput("dropAcks",    64'(a_nack - k0), 64'd1);
        checkOutput("dropAckCyc",  64'(a_ack_cyc - last_bc), 64'd1);
        checkOutput("dropDones",   64'(a_ndone - d0), 64'd0);

        // Single-beat packet into the buffer just taken (keep 3C = 4 bytes)
        w0 = a_nwr; d0 = a_ndone;
        applyStimulus(0, 64'hABCD_0000_1234_0000, 8'h3C, 1'b1, bc);
        idle(3);
        checkOutput("singleWrites", 64'(a_nwr - w0), 64'd1);
        checkOutput("singleAddr",   64'(a_wr_addr[w0]), 64'd0);
        checkOutput("singleInc",    64'(a_wr_inc[w0]), 64'd4);
        checkOutput("singleDones",  64'(a_ndone - d0), 64'd1);
        checkOutput("singleLen",    64'(a_done_len), 64'd4);
        checkOutput("singleDoneCyc", 64'(a_done_cyc), 64'(a_wr_cyc[w0]));

        // Back-to-back drops saturate the 2-bit counter
        w0 = a_nwr; p0 = a_ndrop;
        for (int i = 0; i < 3; i++) applyStimulus(0, pat[i], 8'hFF, 1'b1, bc);
        idle(2);
        checkOutput("satPulses", 64'(a_ndrop - p0), 64'd3);
        checkOutput("satCount",  64'(a_drop_count), 64'd3);
        checkOutput("satWrites", 64'(a_nwr - w0), 64'd0);

        // Backpressure on B: stall while waiting, then capture with latency 2
        w0 = b_nwr; d0 = b_ndone; k0 = b_nack; p0 = b_ndrop; nbp = 0;
        b_TDATA = pat[0]; b_TKEEP = 8'hFF; b_TVALID = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (b_bp_TREADY) nbp++;
        end
        checkOutput("bpStallReady", 64'(nbp), 64'd0);
        checkOutput("bpStallDrops", 64'(b_ndrop - p0), 64'd0);
        @(posedge clk); #1;
        b_rdy = 1'b1; idle(1); b_rdy = 1'b0;
        applyStimulus(1, pat[0], 8'hFF, 1'b0, b_bc[0]);
        applyStimulus(1, pat[1], 8'hFF, 1'b0, b_bc[1]);
        applyStimulus(1, pat[2], 8'h01, 1'b1, b_bc[2]);
        idle(4);
        checkOutput("bpAcks",   64'(b_nack - k0), 64'd1);
        checkOutput("bpWrites", 64'(b_nwr - w0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bpAddr",    64'(b_wr_addr[w0+i]), 64'(i));
            checkOutput("bpLatency", 64'(b_wr_cyc[w0+i] - b_bc[i]), 64'd2);
        end
        checkOutput("bpInc2",    64'(b_wr_inc[w0+2]), 64'd1);
        checkOutput("bpDones",   64'(b_ndone - d0), 64'd1);
        checkOutput("bpLen",     64'(b_done_len), 64'd17);
        checkOutput("bpTrunc",   64'(b_done_trunc), 64'd0);
        checkOutput("bpDoneCyc", 64'(b_done_cyc), 64'(b_wr_cyc[w0+2]));
        checkOutput("bpDrops",   64'(b_ndrop - p0), 64'd0);

        // Reset after 2 beats of a 4-beat packet on A
        a_rdy = 1'b1; idle(1); a_rdy = 1'b0;
        d0 = a_ndone;
        applyStimulus(0, pat[0], 8'hFF, 1'b0, bc);
        applyStimulus(0, pat[1], 8'hFF, 1'b0, bc);
        rst_n = 1'b0;
        a_TDATA = pat[2]; a_TKEEP = 8'hFF; a_TVALID = 1'b1;
        #1;
        checkOutput("midRstWrEn",    64'(a_wr_en), 64'd0);
        checkOutput("midRstAddr",    64'(a_addr), 64'd0);
        checkOutput("midRstData",    a_wr_data, 64'd0);
        checkOutput("midRstInc",     64'(a_byte_inc), 64'd0);
        checkOutput("midRstDropCnt", 64'(a_drop_count), 64'd0);
        checkOutput("midRstLen",     64'(a_pkt_len), 64'd0);
        w0 = a_nwr; p0 = a_ndrop;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, pat[2], 8'hFF, 1'b0, bc);
        applyStimulus(0, pat[3], 8'hFF, 1'b1, bc);
        idle(3);
        checkOutput("midRstDones",   64'(a_ndone - d0), 64'd0);
        checkOutput("midRstWrites",  64'(a_nwr - w0), 64'd0);
        checkOutput("midRstDropped", 64'(a_ndrop - p0), 64'd1);
        checkOutput("midRstCount",   64'(a_drop_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
